// File: rtl/i2s_transmitter.sv
// I2S serialiser: divides master_clk into BCLK/LRCLK and shifts a double-buffered
// mono sample MSB-first into both channel slots, requesting the next sample at each frame start.
module i2s_transmitter #(
  parameter int BCLK_HALF_DIV = 2,
  parameter int SLOT_WIDTH    = 32,
  parameter int SAMPLE_WIDTH  = 16
) (
  input  logic                    master_clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                    sample_valid,
  output logic                    i2s_bclk,
  output logic                    i2s_lrclk,
  output logic                    i2s_sdata,
  output logic                    sample_req,
  output logic                    underrun
);

  localparam int FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int BIT_W      = $clog2(FRAME_BITS);
  localparam int DIV_W      = (BCLK_HALF_DIV > 1) ? $clog2(BCLK_HALF_DIV) : 1;

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT_LEN = BIT_W'(SLOT_WIDTH);
  localparam logic [BIT_W-1:0] SAMP_LEN = BIT_W'(SAMPLE_WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF_DIV - 1);

  logic [DIV_W-1:0]        div_cnt;
  logic [BIT_W-1:0]        bit_cnt;
  logic [SAMPLE_WIDTH-1:0] holding;
  logic [SAMPLE_WIDTH-1:0] frame_reg;
  logic                    fresh;

  logic                    div_wrap;
  logic                    fall_evt;
  logic                    frame_load;
  logic [BIT_W-1:0]        bit_cnt_nxt;
  logic [BIT_W-1:0]        slot_pos;
  logic [SAMPLE_WIDTH-1:0] shifted;
  logic                    sdata_nxt;

  assign div_wrap   = (div_cnt == DIV_LAST);
  assign fall_evt   = enable && div_wrap && i2s_bclk;
  assign frame_load = fall_evt && (bit_cnt == BIT_LAST);

  // Next bit position and the data bit it carries; the slot's first bit is the
  // I2S one-BCLK delay slot, so position p maps to frame_reg[SAMPLE_WIDTH-p].
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    bit_cnt_nxt = '0;
    slot_pos    = '0;
    shifted     = '0;
    sdata_nxt   = 1'b0;

    if (bit_cnt != BIT_LAST) begin
      bit_cnt_nxt = bit_cnt + BIT_W'(1);
    end

    slot_pos = (bit_cnt_nxt >= SLOT_LEN) ? (bit_cnt_nxt - SLOT_LEN) : bit_cnt_nxt;

    if ((slot_pos >= BIT_W'(1)) && (slot_pos <= SAMP_LEN)) begin
      shifted   = frame_reg << (slot_pos - BIT_W'(1));
      sdata_nxt = shifted[SAMPLE_WIDTH-1];
    end
  end

  // Link timing and serial output; everything is forced to its idle value while disabled.
  always_ff @(posedge master_clk or negedge rst) begin
    if (!rst) begin
      div_cnt    <= '0;
      bit_cnt    <= BIT_LAST;
      frame_reg  <= '0;
      i2s_bclk   <= 1'b0;
      i2s_lrclk  <= 1'b0;
      i2s_sdata  <= 1'b0;
      sample_req <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
      sample_req <= 1'b0;
      underrun   <= 1'b0;

      if (!enable) begin
        div_cnt   <= '0;
        bit_cnt   <= BIT_LAST;
        i2s_bclk  <= 1'b0;
        i2s_lrclk <= 1'b0;
        i2s_sdata <= 1'b0;
      end else begin
        div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);

        if (div_wrap) begin
          i2s_bclk <= ~i2s_bclk;
        end

        if (fall_evt) begin
          bit_cnt   <= bit_cnt_nxt;
          i2s_lrclk <= (bit_cnt_nxt >= SLOT_LEN);
          i2s_sdata <= sdata_nxt;
        end

        if (frame_load) begin
          frame_reg  <= holding;
          sample_req <= 1'b1;
          underrun   <= ~fresh;
        end
      end
    end
  end

  // Holding register keeps capturing while disabled; a capture in the load cycle wins over the clear.
  always_ff @(posedge master_clk or negedge rst) begin
    if (!rst) begin
      holding <= '0;
      fresh   <= 1'b0;
    end else if (sample_valid) begin
      holding <= sample_in;
      fresh   <= 1'b1;
    end else if (frame_load) begin
      fresh   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed bench for i2s_transmitter at default parameters: clock-out timing,
// data format, underrun, load-cycle capture, async reset and enable gating.
module tb_i2s_transmitter;

  logic        master_clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_sdata;
  logic        sample_req;
  logic        underrun;

  int checks = 0;
  int errors = 0;

  i2s_transmitter dut (
    .master_clk  (master_clk),
    .rst         (rst),
    .enable      (enable),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .i2s_bclk    (i2s_bclk),
    .i2s_lrclk   (i2s_lrclk),
    .i2s_sdata   (i2s_sdata),
    .sample_req  (sample_req),
    .underrun    (underrun)
  );

  always #5 master_clk = ~master_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge master_clk);
    #1;
  endtask

  task automatic pulse_sample(input logic [15:0] v);
    sample_in    = v;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  function automatic logic [63:0] frm(input logic [15:0] s);
    return {1'b0, s, 15'b0, 1'b0, s, 15'b0};
  endfunction

  // Returns in the cycle sample_req is high (checks the current cycle first).
  task automatic wait_req(output logic ur);
    int n = 0;
    while (sample_req !== 1'b1 && n < 600) begin
      tick();
      n++;
    end
    check("req_wait_bound", {63'b0, sample_req}, 64'd1);
    ur = underrun;
  endtask

  // Captures the 64 bits of one frame on BCLK rising edges; bits[63-i] holds bit_cnt i.
  task automatic get_frame(output logic [63:0] bits, output logic ur);
    int   got = 0;
    int   n   = 0;
    logic prev;
    wait_req(ur);
    bits = '0;
    prev = i2s_bclk;
    while (got < 64 && n < 400) begin
      tick();
      n++;
      if (i2s_bclk && !prev) begin
        bits[63-got] = i2s_sdata;
        got++;
      end
      prev = i2s_bclk;
    end
    check("frame_bits_bound", 64'(got), 64'd64);
  endtask

  // Called right after reset release or re-enable; runs 600 cycles.
  task automatic check_clock_out(input string tag, input logic exp_ur, input int exp_ones);
    int   bclk_err = 0;
    int   req_cnt  = 0;
    int   req_at[3] = '{0, 0, 0};
    int   lr_rise  = 0;
    int   lr_fall  = 0;
    int   lr_high  = 0;
    int   ones     = 0;
    logic first_ur = 1'bx;
    logic prev_lr  = 1'b0;
    for (int n = 1; n <= 600; n++) begin
      tick();
      if (i2s_bclk !== 1'((n / 2) % 2)) bclk_err++;
      if (sample_req === 1'b1) begin
        if (req_cnt == 0) first_ur = underrun;
        if (req_cnt < 3) req_at[req_cnt] = n;
        req_cnt++;
      end
      if (i2s_lrclk && !prev_lr && lr_rise == 0) lr_rise = n;
      if (!i2s_lrclk && prev_lr && lr_fall == 0) lr_fall = n;
      prev_lr = i2s_lrclk;
      if (n >= 4 && n < 260) begin
        if (i2s_lrclk === 1'b1) lr_high++;
        if (i2s_sdata === 1'b1) ones++;
      end
    end
    check({tag, "_bclk_wave"}, 64'(bclk_err), 64'd0);
    check({tag, "_req_count"}, 64'(req_cnt), 64'd3);
    check({tag, "_req0_at"},   64'(req_at[0]), 64'd4);
    check({tag, "_req1_at"},   64'(req_at[1]), 64'd260);
    check({tag, "_req2_at"},   64'(req_at[2]), 64'd516);
    check({tag, "_lr_rise"},   64'(lr_rise), 64'd132);
    check({tag, "_lr_fall"},   64'(lr_fall), 64'd260);
    check({tag, "_lr_high"},   64'(lr_high), 64'd128);
    check({tag, "_first_ur"},  {63'b0, first_ur}, {63'b0, exp_ur});
    check({tag, "_sdata_ones"}, 64'(ones), 64'(exp_ones));
  endtask

  initial begin
    logic [63:0] bits;
    logic        ur;
    int          bad;

    rst          = 1'b0;
    enable       = 1'b1;
    sample_in    = '0;
    sample_valid = 1'b0;

    // Reset clock-out
    repeat (3) tick();
    check("reset_outputs", {59'b0, i2s_bclk, i2s_lrclk, i2s_sdata, sample_req, underrun}, 64'd0);
    rst = 1'b1;
    check_clock_out("rst1", 1'b1, 0);

    // Data format
    wait_req(ur);
    repeat (50) tick();
    pulse_sample(16'hA5C3);
    get_frame(bits, ur);
    check("a5c3_frame", bits, frm(16'hA5C3));
    check("a5c3_ur", {63'b0, ur}, 64'd0);

    // Underrun repeats the last sample
    pulse_sample(16'h1234);
    get_frame(bits, ur);
    check("1234_frame", bits, frm(16'h1234));
    check("1234_ur", {63'b0, ur}, 64'd0);
    get_frame(bits, ur);
    check("1234_rep1_frame", bits, frm(16'h1234));
    check("1234_rep1_ur", {63'b0, ur}, 64'd1);
    get_frame(bits, ur);
    check("1234_rep2_frame", bits, frm(16'h1234));
    check("1234_rep2_ur", {63'b0, ur}, 64'd1);

    // Capture coinciding with the frame load
    sample_in    = 16'h8000;
    sample_valid = 1'b1;
    tick();
    sample_in    = 16'h7FFF;
    tick();
    sample_valid = 1'b0;
    check("simul_load_req", {62'b0, sample_req, underrun}, 64'd2);
    get_frame(bits, ur);
    check("8000_frame", bits, frm(16'h8000));
    get_frame(bits, ur);
    check("7fff_frame", bits, frm(16'h7FFF));
    check("7fff_ur", {63'b0, ur}, 64'd0);

    // Asynchronous reset at bit_cnt=10
    wait_req(ur);
    check("7fff_repeat_ur", {63'b0, ur}, 64'd1);
    repeat (42) tick();
    check("pre_reset_activity", {62'b0, i2s_bclk, i2s_sdata}, 64'd3);
    rst = 1'b0;
    #1;
    check("async_reset_outputs", {59'b0, i2s_bclk, i2s_lrclk, i2s_sdata, sample_req, underrun}, 64'd0);
    repeat (3) tick();
    rst = 1'b1;
    check_clock_out("rst2", 1'b1, 0);

    // Enable gating mid right slot; capture continues while disabled
    pulse_sample(16'h5A5A);
    wait_req(ur);
    check("5a5a_ur", {63'b0, ur}, 64'd0);
    repeat (160) tick();
    check("pre_disable_lr", {63'b0, i2s_lrclk}, 64'd1);
    enable = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (i == 50) begin
        sample_in    = 16'h0F0F;
        sample_valid = 1'b1;
      end else begin
        sample_valid = 1'b0;
      end
      tick();
      if ({i2s_bclk, i2s_lrclk, i2s_sdata, sample_req, underrun} !== 5'b0) bad++;
    end
    sample_valid = 1'b0;
    check("disabled_outputs", 64'(bad), 64'd0);
    enable = 1'b1;
    check_clock_out("reen", 1'b0, 64);
    get_frame(bits, ur);
    check("0f0f_frame", bits, frm(16'h0F0F));
    check("0f0f_ur", {63'b0, ur}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_transmitter.md
Name: i2s_transmitter

Overview:
- Serialises the 16-bit audio sample produced by the nco block onto a standard I2S link (BCLK, LRCLK, SDATA) for the external DAC.
- Generates all I2S clocks by dividing master_clk.
- Double-buffers the sample: a holding register captures each new sample, and a frame register is loaded only at frame start, so the output is one frame (one sample) late but never torn mid-shift.
- Issues a one-cycle sample_req at each frame start; this is the 48 kHz tone_clk strobe for the nco.

Parameters:
- BCLK_HALF_DIV, 2, master_clk cycles per BCLK half-period (≥1).
- SLOT_WIDTH, 32, BCLK cycles per channel slot (≥ SAMPLE_WIDTH+1).
- SAMPLE_WIDTH, 16, sample bits transmitted per slot.

Ports:
- master_clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous active-low reset.
- enable  in  1  link run control; low stops the link.
- sample_in  in  SAMPLE_WIDTH  two's-complement sample, transmitted unmodified.
- sample_valid  in  1  one-cycle strobe; captures sample_in into the holding register.
- i2s_bclk  out  1  bit clock.
- i2s_lrclk  out  1  word select; 0 = left, 1 = right.
- i2s_sdata  out  1  serial data, MSB first.
- sample_req  out  1  one-cycle pulse at each frame load.
- underrun  out  1  one-cycle pulse when a frame loads with no new sample since the previous load.

Behaviour:
Reset values:
- Every output is 0.
- holding, frame_reg, div_cnt, fresh = 0.
- bit_cnt = 2*SLOT_WIDTH-1, so the first falling edge starts a frame.

Clock divider:
- div_cnt counts 0..BCLK_HALF_DIV-1 while enable=1.
- On wrap, i2s_bclk toggles.
- A "fall event" is the cycle in which i2s_bclk goes 1→0.
- First rise at BCLK_HALF_DIV clocks after reset release; first fall at 2*BCLK_HALF_DIV clocks.

Fall-event actions (all registered in the same cycle):
- bit_cnt <= bit_cnt+1, wrapping 2*SLOT_WIDTH-1 → 0.
- i2s_lrclk <= (new bit_cnt ≥ SLOT_WIDTH).
- Slot position p = new bit_cnt mod SLOT_WIDTH.
- i2s_sdata <= frame_reg[SAMPLE_WIDTH-p] for 1 ≤ p ≤ SAMPLE_WIDTH; otherwise 0. This gives standard I2S one-BCLK MSB delay after the LRCLK edge, and the same mono sample in both slots.

Frame load (fall event where bit_cnt wraps to 0):
- frame_reg <= holding.
- sample_req = 1 for that cycle.
- If fresh=0: underrun = 1 for that cycle, and the previous sample is repeated.
- fresh <= 0.

Sample capture:
- sample_valid=1 sets holding <= sample_in and fresh <= 1.
- If sample_valid and a frame load occur in the same cycle: frame_reg takes the old holding, the new sample lands in holding, and fresh ends at 1 (set wins).
- If sample_valid repeats within one frame, the last value wins.

Latency:
- A sample captured before frame load N is transmitted in frame N.
- Its MSB appears on i2s_sdata at the fall event with bit_cnt=1 of frame N.

Frame timing:
- Frame period = 4*SLOT_WIDTH*BCLK_HALF_DIV master_clk cycles (256 at defaults).
- With a 12.288 MHz master_clk at defaults: BCLK = 3.072 MHz, LRCLK = 48 kHz.

Enable:
- enable=0 synchronously forces: div_cnt=0, bit_cnt=2*SLOT_WIDTH-1, i2s_bclk=0, i2s_lrclk=0, i2s_sdata=0.
- sample_req and underrun stay low while disabled.
- holding and fresh keep updating while disabled.
- On re-enable, timing is identical to reset release.

Reset mid-operation:
- rst low clears all state immediately, asynchronously.
- After release, the first frame transmits zeros unless a sample is captured before the first fall event.

Test Plan:
1. Reset clock-out, defaults, enable=1: all outputs 0 during rst. After release, i2s_bclk period 4 cycles at 50% duty; i2s_lrclk period 256 cycles, low 128 / high 128; sample_req every 256 cycles, first at cycle 4.
2. Data format: sample_valid with 16'hA5C3 mid-frame. The next frame's left slot bits 1..16 are 1010_0101_1100_0011 with bits 0 and 17..31 = 0; the right slot is identical. Bits are sampled on BCLK rising edges.
3. Underrun: after 16'h1234 is sent, no further sample_valid for two frames. underrun pulses at both subsequent loads, and both frames carry 16'h1234.
4. Simultaneous load: sample_valid with 16'h7FFF in the frame-load cycle, while holding = 16'h8000. The current frame sends 16'h8000, the next sends 16'h7FFF, and underrun stays 0 at the next load.
5. Reset mid-frame: assert rst at bit_cnt=10. Outputs go 0 within the same cycle, asynchronously. After release, clock timing matches test 1 and the frame carries 16'h0000.
6. Enable gating: drop enable mid-right-slot for 100 cycles. bclk, lrclk and sdata stay 0 with no sample_req; re-enable gives sample_req at 4 cycles, frame aligned as after reset.
